// File: rtl/turn_controller.sv
// turn_controller: turn sequencing for a two-player, 10x10 battleship game.
//
// Flow: IDLE waits for a legal shot from the active player, FIRE strobes the
// external hit detector for one cycle and records its answer, RESULT holds
// the hit/miss indication for RESULT_HOLD cycles, then play either passes to
// the other player or ends in GAMEOVER once a player reaches SHIP_CELLS hits.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   fire, selected_cell : one-cycle shot request and target cell (0..99)
//   p0_ships, p1_ships  : per-player ship maps, stable during play
//   det_hit             : detector answer, sampled during FIRE
//   det_shot            : one-cycle strobe to the detector (FIRE only)
//   det_is_ship         : opponent ship map presented to the detector (FIRE only)
//   det_cell            : latched target cell presented to the detector
//   active_player       : whose turn it is
//   hit_flag, miss_flag : outcome of the last shot, held through RESULT
//   invalid             : one-cycle pulse for a rejected shot
//   shots_p0, shots_p1  : cells each player has already fired at
//   hits_p0, hits_p1    : hit counts, saturating at 100
//   game_over, winner   : end-of-game indication, held until reset
module turn_controller #(
  parameter int SHIP_CELLS  = 17,
  parameter int RESULT_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic [6:0]  selected_cell,
  input  logic [99:0] p0_ships,
  input  logic [99:0] p1_ships,
  input  logic        det_hit,
  output logic        det_shot,
  output logic [99:0] det_is_ship,
  output logic [6:0]  det_cell,
  output logic        active_player,
  output logic        hit_flag,
  output logic        miss_flag,
  output logic        invalid,
  output logic [99:0] shots_p0,
  output logic [99:0] shots_p1,
  output logic [6:0]  hits_p0,
  output logic [6:0]  hits_p1,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_RESULT, S_GAMEOVER} state_t;

  localparam int            CW        = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESULT_HOLD - 1);
  localparam logic [6:0]    WIN_HITS  = 7'(SHIP_CELLS);
  localparam logic [6:0]    MAX_HITS  = 7'd100;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_det_shot, r_player, r_hit_flag, r_miss_flag, r_invalid;
  logic          r_game_over, r_winner;
  logic [99:0]   r_det_is_ship, r_shots_p0, r_shots_p1;
  logic [6:0]    r_det_cell, r_hits_p0, r_hits_p1;

  logic       w_cell_ok, w_fired, w_accept;
  logic [6:0] w_cur_hits;

  // Out-of-range cells are rejected before the shot map is consulted, so the
  // map lookup result is irrelevant for them.
  assign w_cell_ok  = (selected_cell <= 7'd99);
  assign w_fired    = r_player ? r_shots_p1[selected_cell] : r_shots_p0[selected_cell];
  assign w_accept   = w_cell_ok && !w_fired;
  assign w_cur_hits = r_player ? r_hits_p1 : r_hits_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_det_shot    <= 1'b0;
      r_det_is_ship <= '0;
      r_det_cell    <= '0;
      r_player      <= 1'b0;
      r_hit_flag    <= 1'b0;
      r_miss_flag   <= 1'b0;
      r_invalid     <= 1'b0;
      r_shots_p0    <= '0;
      r_shots_p1    <= '0;
      r_hits_p0     <= '0;
      r_hits_p1     <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_invalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fire) begin
            if (w_accept) begin
              r_det_cell    <= selected_cell;
              r_det_shot    <= 1'b1;
              r_det_is_ship <= r_player ? p0_ships : p1_ships;
              r_state       <= S_FIRE;
            end else begin
              r_invalid <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          // det_hit is the detector's combinational answer to this cycle's strobe.
          r_det_shot    <= 1'b0;
          r_det_is_ship <= '0;
          if (r_player) begin
            r_shots_p1[r_det_cell] <= 1'b1;
            if (det_hit && r_hits_p1 < MAX_HITS) r_hits_p1 <= r_hits_p1 + 7'd1;
          end else begin
            r_shots_p0[r_det_cell] <= 1'b1;
            if (det_hit && r_hits_p0 < MAX_HITS) r_hits_p0 <= r_hits_p0 + 7'd1;
          end
          r_hit_flag  <= det_hit;
          r_miss_flag <= !det_hit;
          r_cnt       <= '0;
          r_state     <= S_RESULT;
        end
        S_RESULT: begin
          if (r_cnt == HOLD_LAST) begin
            if (w_cur_hits == WIN_HITS) begin
              r_game_over <= 1'b1;
              r_winner    <= r_player;
              r_state     <= S_GAMEOVER;
            end else begin
              r_player    <= ~r_player;
              r_hit_flag  <= 1'b0;
              r_miss_flag <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ; // GAMEOVER: everything held until reset
      endcase
    end
  end

  assign det_shot      = r_det_shot;
  assign det_is_ship   = r_det_is_ship;
  assign det_cell      = r_det_cell;
  assign active_player = r_player;
  assign hit_flag      = r_hit_flag;
  assign miss_flag     = r_miss_flag;
  assign invalid       = r_invalid;
  assign shots_p0      = r_shots_p0;
  assign shots_p1      = r_shots_p1;
  assign hits_p0       = r_hits_p0;
  assign hits_p1       = r_hits_p1;
  assign game_over     = r_game_over;
  assign winner        = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;
  logic        clk = 1'b0;
  logic        reset, fire, det_hit;
  logic [6:0]  selected_cell;
  logic [99:0] p0_ships, p1_ships;
  logic        det_shot, active_player, hit_flag, miss_flag, invalid, game_over, winner;
  logic [99:0] det_is_ship, shots_p0, shots_p1;
  logic [6:0]  det_cell, hits_p0, hits_p1;

  int errors = 0;
  int checks = 0;
  int shot_pulses = 0;

  turn_controller #(.SHIP_CELLS(2), .RESULT_HOLD(4)) dut (
    .clk(clk), .reset(reset), .fire(fire), .selected_cell(selected_cell),
    .p0_ships(p0_ships), .p1_ships(p1_ships), .det_hit(det_hit),
    .det_shot(det_shot), .det_is_ship(det_is_ship), .det_cell(det_cell),
    .active_player(active_player), .hit_flag(hit_flag), .miss_flag(miss_flag),
    .invalid(invalid), .shots_p0(shots_p0), .shots_p1(shots_p1),
    .hits_p0(hits_p0), .hits_p1(hits_p1), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Hit detector model: combinational lookup of the presented map.
  logic [127:0] det_map_pad;
  assign det_map_pad = {28'd0, det_is_ship};
  assign det_hit     = det_shot & det_map_pad[det_cell];

  always @(negedge clk) if (det_shot === 1'b1) shot_pulses++;

  // Everything the block drives, for whole-state zero checks.
  logic [333:0] all_out;
  assign all_out = {det_shot, det_is_ship, det_cell, active_player, hit_flag, miss_flag,
                    invalid, shots_p0, shots_p1, hits_p0, hits_p1, game_over, winner};

  // Raise fire for one cycle; returns at the falling edge after it was sampled.
  task automatic fire_cell(input logic [6:0] c);
    @(negedge clk);
    fire = 1'b1;
    selected_cell = c;
    @(negedge clk);
    fire = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; fire = 1'b0; selected_cell = 7'd0;
    p0_ships = '0;
    p1_ships = '0;
    p1_ships[5] = 1'b1;
    p1_ships[7] = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_state: got %h want 0", all_out);
    end
  endtask

  task automatic test_hit;
    logic [99:0] exp_shots;
    exp_shots = '0; exp_shots[5] = 1'b1;
    fire_cell(7'd5);
    checks++;
    if ({det_shot, det_cell} !== {1'b1, 7'd5}) begin
      errors++; $display("FAIL hit_fire_strobe: got shot=%b cell=%0d want shot=1 cell=5", det_shot, det_cell);
    end
    checks++;
    if (det_is_ship !== p1_ships) begin
      errors++; $display("FAIL hit_det_map: got %h want %h", det_is_ship, p1_ships);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({hit_flag, miss_flag, det_shot} !== 3'b100) begin
        errors++; $display("FAIL hit_result_cycle%0d: got hit/miss/shot=%b want 100", i, {hit_flag, miss_flag, det_shot});
      end
    end
    checks++;
    if ({hits_p0, shots_p0} !== {7'd1, exp_shots}) begin
      errors++; $display("FAIL hit_counts: got hits=%0d shots=%h want hits=1 shots=%h", hits_p0, shots_p0, exp_shots);
    end
    @(negedge clk);
    checks++;
    if ({active_player, hit_flag, miss_flag} !== 3'b100) begin
      errors++; $display("FAIL hit_turn_pass: got player/hit/miss=%b want 100", {active_player, hit_flag, miss_flag});
    end
  endtask

  task automatic test_miss;
    logic [99:0] exp_shots;
    exp_shots = '0; exp_shots[42] = 1'b1;
    fire_cell(7'd42);
    checks++;
    if ({det_shot, det_cell, det_is_ship} !== {1'b1, 7'd42, p0_ships}) begin
      errors++; $display("FAIL miss_fire_strobe: got shot=%b cell=%0d map=%h", det_shot, det_cell, det_is_ship);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({hit_flag, miss_flag, det_shot, invalid} !== 4'b0100) begin
        errors++; $display("FAIL miss_result_cycle%0d: got hit/miss/shot/inv=%b want 0100", i, {hit_flag, miss_flag, det_shot, invalid});
      end
      // A fire during RESULT must be ignored.
      if (i == 0) begin fire = 1'b1; selected_cell = 7'd43; end
      else fire = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({active_player, hits_p1, hit_flag, miss_flag, invalid} !== {1'b0, 7'd0, 3'b000}) begin
      errors++; $display("FAIL miss_turn_pass: got player=%b hits=%0d flags=%b", active_player, hits_p1, {hit_flag, miss_flag, invalid});
    end
    checks++;
    if (shots_p1 !== exp_shots) begin
      errors++; $display("FAIL miss_shot_map: got %h want %h", shots_p1, exp_shots);
    end
  endtask

  task automatic test_invalid;
    logic [99:0] exp_shots;
    exp_shots = '0; exp_shots[5] = 1'b1;
    fire_cell(7'd5);
    checks++;
    if ({invalid, det_shot, active_player} !== 3'b100) begin
      errors++; $display("FAIL invalid_refire: got inv/shot/player=%b want 100", {invalid, det_shot, active_player});
    end
    @(negedge clk);
    checks++;
    if ({invalid, det_shot} !== 2'b00) begin
      errors++; $display("FAIL invalid_one_cycle: got inv/shot=%b want 00", {invalid, det_shot});
    end
    fire_cell(7'd120);
    checks++;
    if ({invalid, det_shot, active_player} !== 3'b100) begin
      errors++; $display("FAIL invalid_range: got inv/shot/player=%b want 100", {invalid, det_shot, active_player});
    end
    @(negedge clk);
    checks++;
    if ({invalid, hits_p0, shots_p0} !== {1'b0, 7'd1, exp_shots}) begin
      errors++; $display("FAIL invalid_no_change: got inv=%b hits=%0d shots=%h", invalid, hits_p0, shots_p0);
    end
  endtask

  task automatic test_gameover;
    logic [99:0] exp_shots;
    exp_shots = '0; exp_shots[5] = 1'b1; exp_shots[7] = 1'b1;
    fire_cell(7'd7);
    checks++;
    if (det_shot !== 1'b1) begin
      errors++; $display("FAIL win_fire_strobe: got %b want 1", det_shot);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({game_over, winner, active_player, hits_p0} !== {3'b100, 7'd2}) begin
      errors++; $display("FAIL win_gameover: got over/win/player=%b hits=%0d want 100 hits=2", {game_over, winner, active_player}, hits_p0);
    end
    fire_cell(7'd9);
    checks++;
    if ({det_shot, invalid} !== 2'b00) begin
      errors++; $display("FAIL win_fire_ignored: got shot/inv=%b want 00", {det_shot, invalid});
    end
    @(negedge clk);
    checks++;
    if ({game_over, winner, shots_p0} !== {2'b10, exp_shots}) begin
      errors++; $display("FAIL win_held: got over/win=%b shots=%h want 10 shots=%h", {game_over, winner}, shots_p0, exp_shots);
    end
  endtask

  task automatic test_reset_mid_result;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_from_gameover: got %h want 0", all_out);
    end
    fire_cell(7'd5);
    @(negedge clk);
    checks++;
    if ({hit_flag, hits_p0} !== {1'b1, 7'd1}) begin
      errors++; $display("FAIL rst_result_entry: got hit=%b hits=%0d want hit=1 hits=1", hit_flag, hits_p0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid_result: got %h want 0", all_out);
    end
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_stays_idle: got %h want 0", all_out);
    end
    checks++;
    if (shot_pulses !== 4) begin
      errors++; $display("FAIL det_shot_pulses: got %0d want 4", shot_pulses);
    end
  endtask

  initial begin
    test_reset;
    test_hit;
    test_miss;
    test_invalid;
    test_gameover;
    test_reset_mid_result;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
